conv_relu_pool: RTL
===================

Name: conv_relu_pool

Overview:
Downstream stage for the 3x3 convolution engine. It consumes the engine's 16-bit results as a raster-ordered feature map, applies ReLU, requantizes to 8 bits with saturation, and performs a 2x2 stride-2 max-pool. Pooled bytes leave through a valid/ready output FIFO. A pulse marks the end of each frame.

Parameters:
MAP_W, 8, feature-map width in conv results; even, >=2
MAP_H, 8, feature-map height in rows; even, >=2
SHIFT, 4, right-shift applied after ReLU for requantization; 0..15
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (reset when rst==0)
in_valid  input  1  in_data valid this cycle
in_data  input  16  conv result, interpreted as two's-complement signed
in_ready  output  1  block can accept in_data this cycle
out_valid  output  1  out_data holds a pooled byte
out_data  output  8  pooled, requantized value (FIFO head)
out_ready  input  1  consumer takes out_data this cycle
frame_done  output  1  one-cycle pulse, frame fully pooled and drained

Behaviour:
- Reset (rst==0 at a clk edge): FSM->RUN; col=0, row=0; FIFO emptied; hold register and line buffer contents don't-care. Outputs after reset: in_ready=1, out_valid=0, out_data=0, frame_done=0. Reset has priority over all events; mid-frame reset discards the partial frame and all FIFO contents.
- Transfer: an input is accepted when in_valid && in_ready. An output is popped when out_valid && out_ready.
- Per-input datapath, all within the acceptance cycle:
  - r = in_data[15] ? 0 : in_data.
  - q = r >> SHIFT.
  - q8 = (q > 255) ? 255 : q[7:0].
  - Compares are unsigned 8-bit.
- Pooling by position (row, col), col 0..MAP_W-1:
  - row even, col even: hold <= q8.
  - row even, col odd: linebuf[col>>1] <= max(hold, q8). The line buffer holds MAP_W/2 bytes.
  - row odd, col even: hold <= max(linebuf[col>>1], q8).
  - row odd, col odd: push max(hold, q8) into the FIFO.
- Counters: col increments per accepted input and wraps at MAP_W-1 to 0, incrementing row. Acceptance at (MAP_H-1, MAP_W-1) sets row=0, col=0 and moves the FSM to FLUSH.
- FSM:
  - RUN: in_ready = (fifo_count != FIFO_DEPTH).
  - FLUSH: in_ready=0. When fifo_count==0, pulse frame_done for exactly one cycle and return to RUN the next cycle.
  - If the FIFO is already empty on entry to FLUSH (consumer fast), frame_done pulses the cycle after entry.
- Latency: a pooled byte pushed at an accepting edge gives out_valid=1 the following cycle when the FIFO was empty. There is no combinational path from in_* to out_*.
- FIFO: first-word-fall-through.
  - out_data = head entry; it reads 0 when empty.
  - Simultaneous push and pop on a full FIFO is not possible, because in_ready=0 when full. This holds even if out_ready=1 that cycle; in_ready never depends on out_ready.
  - Simultaneous push and pop otherwise: count unchanged, ordering preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- in_valid while in_ready=0: ignored; the source must hold its data.
- Outputs per frame: exactly (MAP_W/2)*(MAP_H/2) bytes, in raster order of pooled windows.

Test Plan:
- Basic pool (MAP_W=4, MAP_H=2, SHIFT=0, out_ready=1): inputs 10,20,30,40 / 5,25,35,1 -> outputs 25 then 40. frame_done pulses once, one cycle after the last output pops.
- ReLU/saturation (MAP_W=2, MAP_H=2, SHIFT=4): inputs 0x8000, 0xFFFF, 0x1000, 0x0010 -> q8 values 0, 0, 255 (256 saturated), 1 -> single output 255. Repeat with 0x0FF0 instead of 0x1000 -> output 255 (unsaturated); with all negative inputs -> output 0.
- Backpressure (defaults, FIFO_DEPTH=4, out_ready=0, stream 8x8 ramp): after the 4th pooled push in_ready=0 and no further inputs are accepted. Raising out_ready drains 4 bytes in order, then in_ready returns to 1 and all 16 outputs are correct.
- Back-to-back frames (MAP_W=4, MAP_H=2): two frames sent with in_valid held high. in_ready=0 during FLUSH. Outputs are 2+2 bytes with two frame_done pulses; the second frame's row/col start at 0.
- Mid-frame reset: drive rst=0 for one cycle after 5 inputs of the basic-pool frame -> next cycle out_valid=0, in_ready=1. A fresh full frame then yields 25 and 40 with no stale data.
- Random in_valid/out_ready gaps (defaults, 100 random frames vs. reference model) -> output stream identical to the model, and frame_done count equals the frame count.

Source files
------------

// File: rtl/conv_relu_pool.sv
// conv_relu_pool
//   Takes the 3x3 convolution engine's signed 16-bit results as a raster-ordered
//   feature map. Each result goes through ReLU and is requantized to an unsigned
//   byte with saturation. A 2x2, stride-2 max-pool then reduces the map, and the
//   pooled bytes leave through a first-word-fall-through valid/ready FIFO.
//   frame_done pulses once a whole frame has been pooled and the FIFO has drained.
//
// Ports
//   clk        : clock, every flop updates on the rising edge
//   rst        : synchronous reset, active-low
//   in_valid   : in_data is valid this cycle
//   in_data    : signed 16-bit conv result
//   in_ready   : the block accepts in_data this cycle
//   out_valid  : out_data holds a pooled byte
//   out_data   : FIFO head byte; reads 0 while the FIFO is empty
//   out_ready  : the consumer takes out_data this cycle
//   frame_done : one-cycle pulse when a frame is fully pooled and drained
module conv_relu_pool #(
    parameter int MAP_W      = 8,
    parameter int MAP_H      = 8,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               frame_done
);

    localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int LB_N  = MAP_W / 2;
    localparam int LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // ReLU followed by the requantizing shift. Negative inputs clamp to 0;
    // anything that still exceeds a byte after the shift saturates to 255.
    function automatic logic [7:0] relu_requant(input logic signed [15:0] x);
        logic [15:0] r;
        logic [15:0] q;
        r = x[15] ? 16'd0 : $unsigned(x);
        q = r >> SHIFT;
        return (q > 16'd255) ? 8'hFF : q[7:0];
    endfunction

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Control state
    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // Datapath state (never reset; contents are rebuilt by every frame)
    logic [7:0]         hold_q, hold_d;
    logic [7:0]         linebuf_q [LB_N];
    logic [7:0]         linebuf_d [LB_N];
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [7:0]         fifo_mem_d [FIFO_DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic [7:0]         q8;
    logic [7:0]         pair_max;
    logic [LB_W-1:0]    lb_idx;

    // in_ready looks only at registered state, never at out_ready, so a full
    // FIFO can never see a push and a pop in the same cycle.
    assign in_ready   = (state_q == ST_RUN) && (cnt_q != CNT_W'(FIFO_DEPTH));
    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? fifo_mem_q[rd_ptr_q] : 8'd0;
    assign frame_done = (state_q == ST_FLUSH) && (cnt_q == '0);

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign q8       = relu_requant(in_data);
    assign pair_max = max_u8(hold_q, q8);
    assign lb_idx   = LB_W'(col_q >> 1);
    // The bottom-right pixel of each 2x2 window completes it.
    assign push     = accept && row_q[0] && col_q[0];

    // Pooling: even rows fold column pairs into the line buffer; odd rows fold
    // the stored pair with their own column pair and emit the window maximum.
    always_comb begin
        hold_d    = hold_q;
        linebuf_d = linebuf_q;
        if (accept && !col_q[0]) begin
            hold_d = row_q[0] ? max_u8(linebuf_q[lb_idx], q8) : q8;
        end
        if (accept && col_q[0] && !row_q[0]) begin
            linebuf_d[lb_idx] = pair_max;
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = pair_max;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (col_q == COL_W'(MAP_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(MAP_H - 1)) begin
                            row_d   = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // frame_done is high during the cycle the FIFO is seen empty.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q     <= hold_d;
        linebuf_q  <= linebuf_d;
        fifo_mem_q <= fifo_mem_d;
    end

endmodule
